// File: rtl/mine_adder_pkg.sv
// Shared constants and result type for the mine_adder arithmetic leaf.
// Result type is sized for the widest legal adder; narrower adders use its low bits.
package mine_adder_pkg;

  localparam int MINE_ADDER_DEF_WIDTH = 4;
  localparam int MINE_ADDER_MAX_WIDTH = 32;

  // {carry, sum} for the widest adder; bit WIDTH holds the carry.
  typedef logic [MINE_ADDER_MAX_WIDTH:0] mine_adder_res_t;

endpackage

// File: rtl/mine_full_adder.sv
// One-bit full adder cell used as a link in the ripple carry chain.
// Purely combinational.
module mine_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  // Propagate term shared by sum and carry.
  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/mine_adder.sv
// Registered ripple-carry adder with carry-in/out and a valid flag.
// Define MINE_ADDER_ACC_EN to add the running-sum output acc.
module mine_adder
  import mine_adder_pkg::*;
#(
  parameter int WIDTH = MINE_ADDER_DEF_WIDTH
) (
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  input  logic             c_in,
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             out_valid
`ifdef MINE_ADDER_ACC_EN
  ,
  output logic [WIDTH-1:0] acc
`endif
);

  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] s_comb;
  mine_adder_res_t  res;

  assign carry[0] = c_in;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_chain
      mine_full_adder u_fa (
        .a    (a[i]),
        .b    (b[i]),
        .cin  (carry[i]),
        .s    (s_comb[i]),
        .cout (carry[i+1])
      );
    end
  endgenerate

  // Pack the chain output as {carry, sum}.
  always_comb begin
    res              = '0;
    res[WIDTH-1:0]   = s_comb;
    res[WIDTH]       = carry[WIDTH];
  end

  // Result registers hold when no operands arrive.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum   <= '0;
      c_out <= 1'b0;
    end else if (in_valid) begin
      sum   <= res[WIDTH-1:0];
      c_out <= res[WIDTH];
    end
  end

  // Valid follows in_valid by exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) out_valid <= 1'b0;
    else     out_valid <= in_valid;
  end

`ifdef MINE_ADDER_ACC_EN
  // Running sum of accepted results; carry out of acc is dropped.
  always_ff @(posedge clk) begin
    if (rst)           acc <= '0;
    else if (in_valid) acc <= acc + res[WIDTH-1:0];
  end
`endif

endmodule

// File: tb/tb_mine_adder.sv
// Self-checking bench for mine_adder at the default 4-bit width.
// Expected values come from plain integer arithmetic on the operands.
module tb_mine_adder;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a, b;
  logic         c_in;
  logic         in_valid;
  logic [W-1:0] sum;
  logic         c_out;
  logic         out_valid;
`ifdef MINE_ADDER_ACC_EN
  logic [W-1:0] acc;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mine_adder #(.WIDTH(W)) dut (
    .b         (b),
    .a         (a),
    .sum       (sum),
    .c_out     (c_out),
    .c_in      (c_in),
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .out_valid (out_valid)
`ifdef MINE_ADDER_ACC_EN
    ,
    .acc       (acc)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int av, input int bv, input int cv, input bit v);
    a        = W'(av);
    b        = W'(bv);
    c_in     = cv[0];
    in_valid = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 1'b0);
    step();
    checks++;
    if ({c_out, sum, out_valid} !== {1'b0, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL reset: got c_out=%b sum=%0d ov=%b want 0 0 0", c_out, sum, out_valid);
    end
    rst = 1'b0;
  endtask

  task automatic test_sweep();
    for (int i = 0; i < 8; i++) begin
      drive(i, 0, 0, 1'b1);
      step();
      checks++;
      if (sum !== W'(i) || c_out !== 1'b0 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL sweep%0d: got c_out=%b sum=%0d ov=%b want 0 %0d 1", i, c_out, sum, out_valid, i);
      end
    end
  endtask

  task automatic test_carry();
    int av[2] = '{15, 15};
    int bv[2] = '{15, 0};
    for (int i = 0; i < 2; i++) begin
      int e = av[i] + bv[i] + 1;
      drive(av[i], bv[i], 1, 1'b1);
      step();
      checks++;
      if ({c_out, sum} !== (W+1)'(e) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL carry%0d: got %0d ov=%b want %0d 1", i, {c_out, sum}, out_valid, e);
      end
    end
  endtask

  task automatic test_hold();
    drive(3, 4, 0, 1'b1);
    step();
    drive(9, 9, 1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (sum !== W'(7) || c_out !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold%0d: got c_out=%b sum=%0d ov=%b want 0 7 0", i, c_out, sum, out_valid);
      end
    end
  endtask

  task automatic test_reset_priority();
    drive(2, 2, 0, 1'b1);
    step();
    rst = 1'b1;
    drive(5, 5, 0, 1'b1);
    step();
    rst = 1'b0;
    checks++;
    if ({c_out, sum, out_valid} !== {1'b0, {W{1'b0}}, 1'b0}) begin
      errors++;
      $display("FAIL rst_prio: got c_out=%b sum=%0d ov=%b want 0 0 0", c_out, sum, out_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2 * M * M; i++) begin
      int av = i % M;
      int bv = (i / M) % M;
      int cv = i / (M * M);
      int e  = av + bv + cv;
      drive(av, bv, cv, 1'b1);
      step();
      checks++;
      if ({c_out, sum} !== (W+1)'(e) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL exh a=%0d b=%0d c=%0d: got %0d ov=%b want %0d", av, bv, cv, {c_out, sum}, out_valid, e);
      end
    end
  endtask

  task automatic test_random();
    int exp_res = 0;
    int exp_acc = 0;
    bit exp_ov  = 1'b0;
    rst = 1'b1;
    drive(0, 0, 0, 1'b0);
    step();
    for (int n = 0; n < 300; n++) begin
      int av = int'($urandom_range(M - 1));
      int bv = int'($urandom_range(M - 1));
      int cv = int'($urandom_range(1));
      bit v  = ($urandom_range(3) != 0);
      bit r  = ($urandom_range(19) == 0);
      rst = r;
      drive(av, bv, cv, v);
      step();
      if (r) begin
        exp_res = 0;
        exp_acc = 0;
        exp_ov  = 1'b0;
      end else begin
        exp_ov = v;
        if (v) begin
          exp_res = av + bv + cv;
          exp_acc = (exp_acc + exp_res) % M;
        end
      end
      checks++;
      if ({c_out, sum} !== (W+1)'(exp_res) || out_valid !== exp_ov) begin
        errors++;
        $display("FAIL rand%0d: got %0d ov=%b want %0d ov=%b", n, {c_out, sum}, out_valid, exp_res, exp_ov);
      end
`ifdef MINE_ADDER_ACC_EN
      checks++;
      if (acc !== W'(exp_acc)) begin
        errors++;
        $display("FAIL rand_acc%0d: got %0d want %0d", n, acc, exp_acc);
      end
`endif
    end
    rst = 1'b0;
  endtask

`ifdef MINE_ADDER_ACC_EN
  task automatic test_acc();
    rst = 1'b1;
    drive(0, 0, 0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(i, 0, 0, 1'b1);
      step();
    end
    checks++;
    if (acc !== W'(28 % M)) begin
      errors++;
      $display("FAIL acc_sum: got %0d want %0d", acc, 28 % M);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (acc !== '0) begin
      errors++;
      $display("FAIL acc_rst: got %0d want 0", acc);
    end
  endtask
`endif

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 1'b0);
    test_reset();
    test_sweep();
    test_carry();
    test_hold();
    test_reset_priority();
    test_back_to_back();
    test_random();
`ifdef MINE_ADDER_ACC_EN
    test_acc();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
